// File: rtl/mem_bus_pkg.sv
// Shared definitions for the single-port memory bus: burst FSM state encoding
// and the default geometry used by both the burst master and slave_memory.
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MEM_SIZE   = 4096;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } burst_state_e;

endpackage

// File: rtl/mem_rd_skid.sv
// One-entry holding register for read beats. A load always wins over a pop,
// so issuing into the slot while it is being emptied keeps one beat per cycle.
module mem_rd_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  free_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    // The slot can accept a new beat if it is empty or its beat leaves this cycle.
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port slave memory: one access per beat with
// auto-incrementing address. Define MEM_BURST_MASTER_BOUNDS_EN to reject
// commands that would run past MEM_SIZE (err pulse instead of execution).
module mem_burst_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;

`ifdef MEM_BURST_MASTER_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_SIZE);

    burst_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  cnt_d;
    logic                  done_q;
    logic                  err_q;
    logic [SUM_W-1:0]      cmd_end_d;
    logic                  cmd_oob_d;
    logic                  wr_beat;
    logic                  rd_issue;
    logic                  rd_free;

    // End address is computed wide enough that it can never wrap.
    assign cmd_end_d = SUM_W'(cmd_addr) + SUM_W'(cmd_len) + SUM_W'(1);
    assign cmd_oob_d = BOUNDS_EN && (cmd_end_d > MEM_LIMIT);

    assign addr_d = addr_q + ADDR_WIDTH'(1);
    assign cnt_d  = cnt_q - LEN_WIDTH'(1);

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign wr_beat   = wr_ready && wr_valid;
    assign rd_issue  = (state_q == READ) && rd_free;

    assign mem_wen   = wr_beat;
    assign mem_ren   = rd_issue;
    assign mem_addr  = addr_q;
    assign mem_wdata = wr_data;
    assign done      = done_q;
    assign err       = err_q;

    mem_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (rd_issue),
        .data_i  (mem_rdata),
        .ready_i (rd_ready),
        .valid_o (rd_valid),
        .data_o  (rd_data),
        .free_o  (rd_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_oob_d) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= cmd_addr;
                            cnt_q   <= cmd_len;
                            state_q <= cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_d;
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_d;
                        if (cnt_q == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last beat already sits in the holding register.
                    if (rd_valid && rd_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master: a reference memory model predicts
// every access, read beat and done/err pulse; a negedge monitor checks them.
module tb_mem_burst_master;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int LW  = 8;
    localparam int MSZ = 4096;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          done, err;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    acc_t          exp_acc_q[$];
    logic [DW-1:0] exp_rd_q[$];
    bit            exp_evt_q[$];    // 0 = done, 1 = err

    logic [DW-1:0] slave_mem [MSZ];
    logic [DW-1:0] ref_mem   [MSZ];

    always #5 clk = ~clk;

    mem_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MSZ), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Slave memory: combinational read qualified by ren, write on the clock edge.
    assign mem_rdata = mem_ren ? slave_mem[mem_addr] : '0;
    always @(posedge clk) begin
        if (mem_wen) slave_mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents an access, beat or pulse.
    bit            hold_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            check("wen_ren_exclusive", 32'(mem_wen && mem_ren), 32'd0);
            if (mem_wen) check("wen_needs_wr_valid", 32'(wr_valid), 32'd1);
            if (mem_wen || mem_ren) begin
                if (exp_acc_q.size() == 0) begin
                    check("unexpected_access", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    acc_t e;
                    e = exp_acc_q.pop_front();
                    check("acc_we", 32'(mem_wen), 32'(e.we));
                    check("acc_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("acc_wdata", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (hold_prev) begin
                check("stall_rd_valid", 32'(rd_valid), 32'd1);
                check("stall_rd_data", 32'(rd_data), 32'(held_data));
            end
            if (rd_valid && !rd_ready) check("ren_while_full", 32'(mem_ren), 32'd0);
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) check("unexpected_rd", 32'(rd_data), 32'hFFFF_FFFF);
                else check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (done) begin
                if (exp_evt_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("done_kind", 32'd0, 32'(exp_evt_q.pop_front()));
            end
            if (err) begin
                if (exp_evt_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
                else check("err_kind", 32'd1, 32'(exp_evt_q.pop_front()));
            end
            hold_prev = rd_valid && !rd_ready;
            held_data = rd_data;
        end
    end

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
    endtask

    // Offer a command; returns just after the negedge of the accepting cycle.
    task automatic issue_cmd(input bit wr, input int addr, input int len, output bit done_seen);
        int cyc = 0;
        @(posedge clk); #1;
        idle_inputs();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[LW-1:0];
        done_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            cyc++;
            if (cyc > 500) begin
                fail_now("cmd_accept");
                break;
            end
            @(posedge clk); #1;
        end
        done_seen = done;
    endtask

    // mode 0: valid/ready always 1; 1: random; 2: write gaps of 3 / read ready 1,0,0.
    task automatic do_burst(input bit wr, input int addr, input int len, input int mode,
                            input bit seq_data, output bit done_seen);
        logic [DW-1:0] wq [256];
        logic [AW-1:0] a;
        bit rejected;
        int beat = 0, cyc = 0, gap = 0, first = -1, last = -1, maxgap = 0;
`ifdef MEM_BURST_MASTER_BOUNDS_EN
        rejected = (addr + len + 1 > MSZ);
`else
        rejected = 1'b0;
`endif
        if (rejected) begin
            exp_evt_q.push_back(1'b1);
        end else begin
            for (int i = 0; i <= len; i++) begin
                a = AW'((addr + i) % MSZ);
                if (wr) begin
                    wq[i] = seq_data ? DW'(8'hA0 + i) : DW'($urandom);
                    ref_mem[a] = wq[i];
                    exp_acc_q.push_back('{we: 1'b1, addr: a, data: wq[i]});
                end else begin
                    exp_acc_q.push_back('{we: 1'b0, addr: a, data: '0});
                    exp_rd_q.push_back(ref_mem[a]);
                end
            end
            exp_evt_q.push_back(1'b0);
        end
        issue_cmd(wr, addr, len, done_seen);
        if (rejected) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("cmd_ready_after_reject", 32'(cmd_ready), 32'd1);
        end else if (wr) begin
            while (beat <= len) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                case (mode)
                    0:       wr_valid = 1'b1;
                    1:       wr_valid = ($urandom_range(0, 9) < 7);
                    default: wr_valid = (gap >= 3);
                endcase
                wr_data = wq[beat];
                @(negedge clk);
                cyc++;
                if (wr_valid && wr_ready) begin
                    beat++;
                    gap = 0;
                end else if (!wr_valid) begin
                    gap++;
                end
                if (cyc > 3000) begin
                    fail_now("write_beats");
                    break;
                end
            end
            if (mode == 0) check("wr_burst_cycles", 32'(cyc), 32'(len + 1));
        end else begin
            while (beat <= len) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                case (mode)
                    0:       rd_ready = 1'b1;
                    1:       rd_ready = ($urandom_range(0, 9) < 7);
                    default: rd_ready = (gap % 3 == 0);
                endcase
                gap++;
                @(negedge clk);
                cyc++;
                if (rd_valid && rd_ready) begin
                    if (first < 0) first = cyc;
                    if (last >= 0 && cyc - last > maxgap) maxgap = cyc - last;
                    last = cyc;
                    beat++;
                end
                if (cyc > 3000) begin
                    fail_now("read_beats");
                    break;
                end
            end
            if (mode == 0) begin
                check("rd_first_latency", 32'(first), 32'd2);
                if (len > 0) check("rd_beat_spacing", 32'(maxgap), 32'd1);
            end
        end
    endtask

    initial begin
        bit ds;
        int got;
        logic [DW-1:0] d;
        for (int i = 0; i < MSZ; i++) begin
            d = DW'($urandom);
            slave_mem[i] = d;
            ref_mem[i]   = d;
        end
        idle_inputs();
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_mem_en", 32'({mem_wen, mem_ren}), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_burst(1'b1, 'h010, 3, 0, 1'b1, ds);
        do_burst(1'b0, 'h010, 3, 0, 1'b0, ds);
        do_burst(1'b0, 'h00E, 4, 2, 1'b0, ds);
        do_burst(1'b1, 'hFFE, 3, 0, 1'b0, ds);
        do_burst(1'b0, 'hFFE, 3, 0, 1'b0, ds);
        do_burst(1'b1, 'h300, 1, 2, 1'b0, ds);
        do_burst(1'b0, 'h300, 1, 1, 1'b0, ds);

        // Reset in the middle of a read burst, after two beats were delivered.
        for (int i = 0; i < 8; i++) begin
            exp_acc_q.push_back('{we: 1'b0, addr: AW'('h200 + i), data: '0});
            exp_rd_q.push_back(ref_mem['h200 + i]);
        end
        exp_evt_q.push_back(1'b0);
        issue_cmd(1'b0, 'h200, 7, ds);
        got = 0;
        for (int c = 0; c < 50 && got < 2; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            rd_ready  = 1'b1;
            @(negedge clk);
            if (rd_valid && rd_ready) got++;
        end
        check("rst_test_beats", 32'(got), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_acc_q.delete();
        exp_rd_q.delete();
        exp_evt_q.delete();
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        do_burst(1'b1, 'h200, 2, 0, 1'b0, ds);
        do_burst(1'b0, 'h200, 2, 0, 1'b0, ds);

        // Single-beat write then read, second command offered the done cycle.
        do_burst(1'b1, 'h555, 0, 0, 1'b0, ds);
        do_burst(1'b0, 'h555, 0, 0, 1'b0, ds);
        check("b2b_accept_on_done", 32'(ds), 32'd1);

        do_burst(1'b1, 'h100, 255, 1, 1'b0, ds);
        do_burst(1'b0, 'h100, 255, 1, 1'b0, ds);

        for (int n = 0; n < 40; n++) begin
            do_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, MSZ - 1)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0, ds);
        end

        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("acc_queue_empty", 32'(exp_acc_q.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
        check("evt_queue_empty", 32'(exp_evt_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the single-port slave memory interface (wen/ren/addr/wdata/rdata, combinational read data qualified by ren).
- Accepts burst commands (start address, beat count, direction) over a valid/ready handshake.
- Streams write beats in, or read beats out, each over its own valid/ready channel, driving one memory access per beat with auto-incrementing address.
- Sits between a host/DMA-side requester and a slave_memory instance.

Parameters:
- ADDR_WIDTH, 12: memory address width; matches the slave.
- DATA_WIDTH, 8: data beat width.
- MEM_SIZE, 4096: addressable locations in the target slave; used only by the optional feature.
- LEN_WIDTH, 8: burst length field width; a burst is cmd_len+1 beats (1..256).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle, can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_WIDTH  write beat data.
- rd_valid  out  1  read beat held.
- rd_ready  in  1  downstream takes the read beat.
- rd_data  out  DATA_WIDTH  read beat data.
- done  out  1  one-cycle pulse: burst finished.
- err  out  1  one-cycle pulse: command rejected (optional feature only; tied 0 otherwise).
- mem_wen  out  1  to slave wen.
- mem_ren  out  1  to slave ren.
- mem_addr  out  ADDR_WIDTH  to slave addr.
- mem_wdata  out  DATA_WIDTH  to slave wdata.
- mem_rdata  in  DATA_WIDTH  from slave rdata.

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst, sampled on posedge clk.
- Reset values:
  - State IDLE.
  - cmd_ready = 1.
  - wr_ready, rd_valid, done, err, mem_wen, mem_ren = 0.
  - rd_data, mem_addr, beat counter = 0.
- Reset mid-burst: the burst is abandoned, no done pulse, and the held read beat is dropped.
- State machine: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr into the address register and len into the beat counter.
  - Go to WRITE if cmd_write, else READ.
  - cmd_ready = 0 in every other state.
- WRITE:
  - wr_ready = 1.
  - mem_wen = wr_valid (combinational); mem_wdata = wr_data; mem_addr = address register.
  - On each accepted beat: address +1, counter −1.
  - On the beat accepted with counter == 0: next state IDLE, done pulses the following cycle.
- READ:
  - mem_ren = 1 when the holding register is free or being emptied this cycle (!rd_valid | rd_ready).
  - On a ren cycle: rd_data <= mem_rdata; rd_valid <= 1; address +1, counter −1.
  - After the last issue (counter == 0), go to DRAIN.
- DRAIN:
  - No memory access.
  - When rd_valid & rd_ready: rd_valid <= 0, go to IDLE, done pulses the following cycle.
- Throughput: one beat per cycle in both directions under continuous valid/ready. Read latency is one cycle from the issue cycle to rd_valid.
- rd_valid and rd_data are stable while rd_ready is low (no beat lost or duplicated under backpressure).
- Address arithmetic is ADDR_WIDTH-bit modulo: 0xFFF+1 wraps to 0x000.
- mem_wen and mem_ren are never both high. mem_addr holds its last value when no access is in progress.
- A new command is accepted no earlier than the cycle done is high; cmd_ready rises in that same cycle.

Optional Feature:
- Macro: MEM_BURST_MASTER_BOUNDS_EN.
- Defined:
  - In IDLE, a command with cmd_addr + cmd_len + 1 > MEM_SIZE (computed at ADDR_WIDTH+LEN_WIDTH+1 bits) is consumed, not executed.
  - err pulses one cycle later and the state stays IDLE.
  - done is not pulsed for a rejected command.
- Undefined: no check, addresses wrap silently, err tied to 0.

Decomposition:
- Package mem_bus_pkg holds:
  - the state encoding typedef (IDLE/WRITE/READ/DRAIN);
  - default-width localparams shared with slave_memory (ADDR_WIDTH 12, DATA_WIDTH 8, MEM_SIZE 4096).
- One natural sub-module: mem_rd_skid, the one-entry read holding register with the valid/ready logic. Everything else stays in the top.

Test Plan:
- Write then read back:
  - Stimulus: write burst addr 0x010, len 3, data A0..A3 with wr_valid always 1; then read burst addr 0x010, len 3 with rd_ready always 1.
  - Required: mem_wen exactly 4 cycles at 0x010..0x013; rd_data A0..A3 on consecutive cycles; done once per burst.
- Read backpressure:
  - Stimulus: read len 4 with rd_ready toggling 1,0,0,1,...
  - Required: 5 beats in order, none lost or duplicated, rd_data stable while stalled, mem_ren never high while the holding register is full and rd_ready is 0.
- Address wrap:
  - Stimulus: write burst addr 0xFFE, len 3.
  - Required: accesses at 0xFFE, 0xFFF, 0x000, 0x001.
  - With MEM_BURST_MASTER_BOUNDS_EN defined: no mem_wen, err pulses once, cmd_ready back to 1.
- Write stall:
  - Stimulus: write len 1 with wr_valid gaps of 3 cycles.
  - Required: mem_wen only on wr_valid cycles; address advances only on accepted beats.
- Reset mid-burst:
  - Stimulus: assert rst during a READ after 2 beats.
  - Required: next cycle cmd_ready = 1, rd_valid = 0, no done pulse; a new burst then runs correctly.
- Single-beat back-to-back:
  - Stimulus: len 0 read immediately after len 0 write.
  - Required: each takes one access; the second command is accepted the cycle done is high.
